// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Deserialises an LSB-first bit stream into WIDTH-bit words and hands them
//   to a consumer through a valid/ready output register.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   s_in       serial data bit
//   s_valid    qualifies s_in; bits are only taken when high
//   s_start    marks the current accepted bit as bit 0 of a new frame
//   d_out      last completed word (registered)
//   d_valid    d_out holds a word not yet taken by the consumer
//   d_ready    consumer takes d_out on an edge with d_valid & d_ready
//   busy       a frame is partially received
//   frame_err  one-cycle pulse on a framing error
//   overrun    sticky: a completed word was dropped; cleared only by reset

module serial_word_receiver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             complete;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] first_bit;

  // Word as it would look after shifting in the current bit.
  assign word      = {s_in, shreg_q[WIDTH-1:1]};
  // A new frame starts with only the MSB populated so no stale bits leak in.
  assign first_bit = {s_in, {(WIDTH - 1){1'b0}}};

  // Frame FSM: next state, shift register, bit counter, framing errors.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    ferr_d   = 1'b0;
    complete = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          if (s_start) begin
            shreg_d = first_bit;
            cnt_d   = OneCnt;
            state_d = StShift;
          end else begin
            // Stray bit outside a frame: discard it.
            ferr_d = 1'b1;
          end
        end
      end

      StShift: begin
        if (s_valid) begin
          if (s_start) begin
            // Abandon the partial frame; this bit becomes bit 0 of a new one.
            ferr_d  = 1'b1;
            shreg_d = first_bit;
            cnt_d   = OneCnt;
          end else if (cnt_q == LastCnt) begin
            complete = 1'b1;
            shreg_d  = '0;
            cnt_d    = '0;
            state_d  = StIdle;
          end else begin
            shreg_d = word;
            cnt_d   = cnt_q + OneCnt;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  // Output register: a finished word is dropped only when the held word is
  // still pending and the consumer is not taking it on this same edge.
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_d    = ovr_q;

    if (complete) begin
      if (!dvalid_q || d_ready) begin
        dout_d   = word;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dvalid_q && d_ready) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign d_out     = dout_q;
  assign d_valid   = dvalid_q;
  assign busy      = (state_q == StShift);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

`ifndef SYNTHESIS
  // Counter never rests beyond the last bit index.
  a_cnt_range : assert property (@(posedge clk) disable iff (reset)
    cnt_q <= LastCnt);

  // Counter is zero exactly when idle.
  a_cnt_idle : assert property (@(posedge clk) disable iff (reset)
    (state_q == StIdle) == (cnt_q == '0));

  // A held, unconsumed word must not change.
  a_dout_stable : assert property (@(posedge clk) disable iff (reset)
    (dvalid_q && !d_ready) |=> (dout_q == $past(dout_q)));

  // Overrun is sticky outside reset.
  a_ovr_sticky : assert property (@(posedge clk) disable iff (reset)
    ovr_q |=> ovr_q);
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed testbench for serial_word_receiver (WIDTH=8).
module tb_serial_word_receiver;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         s_in;
  logic         s_valid;
  logic         s_start;
  logic [W-1:0] d_out;
  logic         d_valid;
  logic         d_ready;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  serial_word_receiver #(
    .WIDTH(W)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .s_in     (s_in),
    .s_valid  (s_valid),
    .s_start  (s_start),
    .d_out    (d_out),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send nbits of w LSB first, start on bit 0, with random idle gaps up to
  // max_gap. restart: bit 0 is expected to abort a partial frame. rdy_last:
  // raise d_ready only for the final bit. dv0: d_valid must stay low until
  // the last bit has been accepted.
  task automatic send_word(input logic [W-1:0] w, input int nbits, input int max_gap,
                           input bit restart, input bit rdy_last, input bit dv0);
    int g;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0 && max_gap > 0) begin
        g = $urandom_range(max_gap, 0);
        repeat (g) begin
          s_valid = 1'b0;
          s_in    = 1'($urandom);
          s_start = 1'($urandom);
          tick();
          check("gap_busy", 32'(busy), 32'd1);
          check("gap_ferr", 32'(frame_err), 32'd0);
        end
      end
      if (rdy_last && i == W - 1) d_ready = 1'b1;
      s_valid = 1'b1;
      s_in    = w[i];
      s_start = (i == 0);
      tick();
      check("bit_busy", 32'(busy), (i != W - 1) ? 32'd1 : 32'd0);
      check("bit_ferr", 32'(frame_err), (restart && i == 0) ? 32'd1 : 32'd0);
      if (dv0 && i < W - 1) check("early_dvalid", 32'(d_valid), 32'd0);
    end
    s_valid = 1'b0;
    s_start = 1'b0;
    s_in    = 1'b0;
  endtask

  task automatic idle_tick();
    s_valid = 1'b0;
    s_start = 1'b0;
    tick();
  endtask

  initial begin
    // Reset for two cycles with random inputs.
    reset = 1'b1;
    repeat (2) begin
      s_in    = 1'($urandom);
      s_valid = 1'($urandom);
      s_start = 1'($urandom);
      d_ready = 1'($urandom);
      tick();
    end
    reset   = 1'b0;
    s_in    = 1'b0;
    s_valid = 1'b0;
    s_start = 1'b0;
    d_ready = 1'b1;
    check("rst_dout", 32'(d_out), 32'h0);
    check("rst_dvalid", 32'(d_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // 0xA5 on consecutive cycles, consumer always ready.
    send_word(8'hA5, 8, 0, 1'b0, 1'b0, 1'b1);
    check("a5_dvalid", 32'(d_valid), 32'd1);
    check("a5_dout", 32'(d_out), 32'hA5);
    idle_tick();
    check("a5_dvalid_drop", 32'(d_valid), 32'd0);
    check("a5_dout_hold", 32'(d_out), 32'hA5);
    check("a5_ovr", 32'(overrun), 32'd0);

    // 0x5A with random gaps.
    send_word(8'h5A, 8, 3, 1'b0, 1'b0, 1'b1);
    check("5a_dvalid", 32'(d_valid), 32'd1);
    check("5a_dout", 32'(d_out), 32'h5A);
    idle_tick();
    check("5a_dvalid_drop", 32'(d_valid), 32'd0);

    // Overrun: consumer stalled across two words.
    d_ready = 1'b0;
    send_word(8'h3C, 8, 1, 1'b0, 1'b0, 1'b1);
    check("3c_dout", 32'(d_out), 32'h3C);
    check("3c_ovr", 32'(overrun), 32'd0);
    send_word(8'hC3, 8, 0, 1'b0, 1'b0, 1'b0);
    check("c3_dout", 32'(d_out), 32'h3C);
    check("c3_dvalid", 32'(d_valid), 32'd1);
    check("c3_ovr", 32'(overrun), 32'd1);
    d_ready = 1'b1;
    idle_tick();
    check("ovr_dvalid", 32'(d_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Restart mid-frame, then a stray bit in idle.
    send_word(8'hFF, 3, 0, 1'b0, 1'b0, 1'b1);
    send_word(8'h81, 8, 0, 1'b1, 1'b0, 1'b1);
    check("81_dout", 32'(d_out), 32'h81);
    check("81_dvalid", 32'(d_valid), 32'd1);
    d_ready = 1'b0;
    s_valid = 1'b1;
    s_start = 1'b0;
    s_in    = 1'b1;
    tick();
    check("stray_ferr", 32'(frame_err), 32'd1);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_dvalid", 32'(d_valid), 32'd1);
    check("stray_dout", 32'(d_out), 32'h81);
    idle_tick();
    check("stray_ferr_end", 32'(frame_err), 32'd0);
    d_ready = 1'b1;
    idle_tick();
    check("81_consumed", 32'(d_valid), 32'd0);

    // Reset mid-frame, with a valid bit presented during reset.
    send_word(8'hFF, 4, 0, 1'b0, 1'b0, 1'b1);
    reset   = 1'b1;
    s_valid = 1'b1;
    s_in    = 1'b1;
    s_start = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    check("mid_rst_dout", 32'(d_out), 32'h0);
    send_word(8'h0F, 8, 0, 1'b0, 1'b0, 1'b1);
    check("0f_dout", 32'(d_out), 32'h0F);
    check("0f_dvalid", 32'(d_valid), 32'd1);
    check("0f_ovr", 32'(overrun), 32'd0);
    idle_tick();

    // Completion on the same edge as a consume replaces the word.
    d_ready = 1'b0;
    send_word(8'h11, 8, 0, 1'b0, 1'b0, 1'b1);
    check("11_dout", 32'(d_out), 32'h11);
    send_word(8'h22, 8, 2, 1'b0, 1'b1, 1'b0);
    check("22_dout", 32'(d_out), 32'h22);
    check("22_dvalid", 32'(d_valid), 32'd1);
    check("22_ovr", 32'(overrun), 32'd0);
    idle_tick();
    check("22_consumed", 32'(d_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
